// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame controller: start detection, 3x majority sampling, LSB-first
// deserialisation, parity/stop checking and one-cycle result pulses.
module uart_rx_frame_ctrl #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [5:0]            Prescale,
   input  logic [4:0]            edge_cnt,
   input  logic [3:0]            bit_cnt,
   output logic                  cnt_enable,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err,
   output logic                  busy
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH);
   localparam logic [3:0] BIT_LIMIT = 4'(DATA_WIDTH + 2);

   state_t state, state_nxt;

   logic [5:0]            pre_q;
   logic                  par_en_q, par_typ_q;
   logic [DATA_WIDTH-1:0] shreg;
   logic                  samp0, samp1, bit_val, par_fail;

   logic [5:0] s_mid, s_m1, s_p1, s_p2, p_m1, edge6;
   logic       at_sm1, at_smid, at_sp1, at_sp2, last_edge, maj;
   logic       cap_cfg, set_pfail, ld_pdata, dv_nxt, pe_nxt, se_nxt;

   // Sample points derive from the prescale latched at start detection.
   assign s_mid     = pre_q >> 1;
   assign s_m1      = s_mid - 6'd1;
   assign s_p1      = s_mid + 6'd1;
   assign s_p2      = s_mid + 6'd2;
   assign p_m1      = pre_q - 6'd1;
   assign edge6     = {1'b0, edge_cnt};
   assign at_sm1    = (edge6 == s_m1);
   assign at_smid   = (edge6 == s_mid);
   assign at_sp1    = (edge6 == s_p1);
   assign at_sp2    = (edge6 == s_p2);
   assign last_edge = (edge6 == p_m1);
   assign maj       = (samp0 & samp1) | (samp0 & RX_IN) | (samp1 & RX_IN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cap_cfg   = 1'b0;
      set_pfail = 1'b0;
      ld_pdata  = 1'b0;
      dv_nxt    = 1'b0;
      pe_nxt    = 1'b0;
      se_nxt    = 1'b0;
      case (state)
         IDLE: begin
            if (!RX_IN) begin
               state_nxt = START;
               cap_cfg   = 1'b1;
            end
         end
         START: begin
            if (last_edge && bit_cnt == 4'd0) state_nxt = bit_val ? IDLE : DATA;
         end
         DATA: begin
            if (last_edge && bit_cnt == LAST_DATA) state_nxt = par_en_q ? PARITY : STOP;
         end
         PARITY: begin
            if (at_sp2 && (bit_val != (^shreg ^ par_typ_q))) set_pfail = 1'b1;
            if (last_edge) state_nxt = STOP;
         end
         STOP: begin
            // Resolve at mid-stop so a start bit with zero idle time is still caught.
            if (at_sp2) begin
               state_nxt = IDLE;
               dv_nxt    = bit_val & ~par_fail;
               ld_pdata  = bit_val & ~par_fail;
               pe_nxt    = par_fail;
               se_nxt    = ~bit_val;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Frame overrun (illegal prescale) abandons the frame silently.
      if (state != IDLE && bit_cnt > BIT_LIMIT) begin
         state_nxt = IDLE;
         ld_pdata  = 1'b0;
         dv_nxt    = 1'b0;
         pe_nxt    = 1'b0;
         se_nxt    = 1'b0;
      end
   end

   assign cnt_enable = (state != IDLE);
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q      <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         shreg      <= '0;
         samp0      <= 1'b1;
         samp1      <= 1'b1;
         bit_val    <= 1'b1;
         par_fail   <= 1'b0;
         P_DATA     <= '0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
      end else begin
         if (cap_cfg) begin
            pre_q     <= Prescale;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            par_fail  <= 1'b0;
         end else if (set_pfail) begin
            par_fail  <= 1'b1;
         end
         if (state != IDLE) begin
            if (at_sm1)  samp0   <= RX_IN;
            if (at_smid) samp1   <= RX_IN;
            if (at_sp1)  bit_val <= maj;
         end
         if (state == DATA && at_sp1) shreg <= {maj, shreg[DATA_WIDTH-1:1]};
         if (ld_pdata) P_DATA <= shreg;
         data_valid <= dv_nxt;
         par_err    <= pe_nxt;
         stp_err    <= se_nxt;
      end
   end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: models the edge/bit counter, drives serial frames and
// compares pulse counts and P_DATA against expectations derived from frame contents.
module tb_uart_rx_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       RX_IN = 1'b1;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic [5:0] Prescale = 6'd8;
   logic [4:0] edge_cnt;
   logic [3:0] bit_cnt;
   logic       cnt_enable, data_valid, par_err, stp_err, busy;
   logic [7:0] P_DATA;

   int n_chk = 0;
   int n_err = 0;
   int n_dv = 0, n_pe = 0, n_se = 0;
   logic [7:0] pd_log [0:511];
   logic [7:0] last_pd = 8'h00;

   uart_rx_frame_ctrl #(.DATA_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
      .Prescale(Prescale), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .cnt_enable(cnt_enable),
      .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Edge/bit counter: cleared while disabled, wraps edge at Prescale-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else if (!cnt_enable) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else if ({1'b0, edge_cnt} == Prescale - 6'd1) begin
         edge_cnt <= '0;
         bit_cnt  <= bit_cnt + 4'd1;
      end else begin
         edge_cnt <= edge_cnt + 5'd1;
      end
   end

   always @(negedge clk) begin
      if (data_valid) begin
         if (n_dv < 512) pd_log[n_dv[8:0]] <= P_DATA;
         n_dv <= n_dv + 1;
      end
      if (par_err) n_pe <= n_pe + 1;
      if (stp_err) n_se <= n_se + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drives start, data LSB-first, optional parity, stop, then idle. Only the first
   // nbits_max frame bits are sent when it is smaller than the frame. One cycle at
   // (gbit, gpos) can be inverted to model a glitch.
   task automatic send_frame(input int pre, input bit pen, input bit ptyp, input logic [7:0] data,
                             input bit flip, input bit stop, input int idle, input int nbits_max,
                             input int gbit, input int gpos);
      logic [10:0] bits;
      int nb;
      bit pbit;
      Prescale = 6'(pre);
      PAR_EN   = pen;
      PAR_TYP  = ptyp;
      pbit     = bit'($countones(data) % 2) ^ ptyp ^ flip;
      bits     = '1;
      bits[0]  = 1'b0;
      bits[8:1] = data;
      if (pen) begin
         bits[9]  = pbit;
         bits[10] = stop;
         nb = 11;
      end else begin
         bits[9] = stop;
         nb = 10;
      end
      for (int b = 0; b < nb && b < nbits_max; b++)
         for (int j = 0; j < pre; j++) begin
            @(negedge clk);
            RX_IN = (b == gbit && j == gpos) ? ~bits[b] : bits[b];
         end
      if (nbits_max >= nb)
         for (int k = 0; k < idle; k++) begin
            @(negedge clk);
            RX_IN = 1'b1;
         end
   endtask

   task automatic run_frame(input string name, input int pre, input bit pen, input bit ptyp,
                            input logic [7:0] data, input bit flip, input bit stop,
                            input int ev, input int epe, input int ese, input logic [7:0] epd);
      int s_dv, s_pe, s_se;
      s_dv = n_dv; s_pe = n_pe; s_se = n_se;
      send_frame(pre, pen, ptyp, data, flip, stop, 2 * pre + 4, 99, -1, 0);
      chk({name, ".valid"}, n_dv - s_dv, ev);
      chk({name, ".par_err"}, n_pe - s_pe, epe);
      chk({name, ".stp_err"}, n_se - s_se, ese);
      chk({name, ".P_DATA"}, int'(P_DATA), int'(epd));
      chk({name, ".busy"}, int'(busy), 0);
      if (ev != 0) last_pd = epd;
   endtask

   typedef struct {
      int         pre;
      bit         pen, ptyp;
      logic [7:0] data;
      bit         flip, stop;
      int         ev, epe, ese;
      logic [7:0] epd;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int s_dv, s_pe, s_se;
      vecs[0] = '{8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1, 0, 0, 8'hA5};
      vecs[1] = '{16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1, 0, 0, 8'h3C};
      vecs[2] = '{16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 0, 1, 0, 8'h3C};
      vecs[3] = '{32, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 0, 0, 1, 8'h3C};
      vecs[4] = '{32, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b1, 1, 0, 0, 8'h7E};
      vecs[5] = '{16, 1'b1, 1'b1, 8'h96, 1'b1, 1'b0, 0, 1, 1, 8'h7E};
      vecs[6] = '{8,  1'b1, 1'b1, 8'h0F, 1'b0, 1'b1, 1, 0, 0, 8'h0F};

      repeat (3) @(negedge clk);
      chk("rst.busy", int'(busy), 0);
      chk("rst.cnt_enable", int'(cnt_enable), 0);
      chk("rst.P_DATA", int'(P_DATA), 0);
      chk("rst.pulses", int'({data_valid, par_err, stp_err}), 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 7; i++)
         run_frame($sformatf("vec%0d", i), vecs[i].pre, vecs[i].pen, vecs[i].ptyp, vecs[i].data,
                   vecs[i].flip, vecs[i].stop, vecs[i].ev, vecs[i].epe, vecs[i].ese, vecs[i].epd);

      // Two-cycle low glitch on an idle line.
      Prescale = 6'd8; PAR_EN = 1'b0;
      s_dv = n_dv; s_pe = n_pe; s_se = n_se;
      @(negedge clk); RX_IN = 1'b0;
      @(negedge clk); RX_IN = 1'b0;
      @(negedge clk); RX_IN = 1'b1;
      repeat (2) @(negedge clk);
      chk("glitch.busy_mid", int'(busy), 1);
      repeat (12) @(negedge clk);
      chk("glitch.busy_end", int'(busy), 0);
      chk("glitch.cnt_enable", int'(cnt_enable), 0);
      chk("glitch.pulses", (n_dv - s_dv) + (n_pe - s_pe) + (n_se - s_se), 0);
      run_frame("after_glitch", 8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1, 0, 0, 8'h55);

      // Inverted centre sample of data bit 3 is outvoted.
      s_dv = n_dv; s_pe = n_pe; s_se = n_se;
      send_frame(16, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 36, 99, 4, 9);
      chk("maj.valid", n_dv - s_dv, 1);
      chk("maj.errs", (n_pe - s_pe) + (n_se - s_se), 0);
      chk("maj.P_DATA", int'(P_DATA), 8'h00);

      // Back-to-back frames, no idle between stop and next start.
      s_dv = n_dv;
      send_frame(8, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 0, 99, -1, 0);
      send_frame(8, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 0, 99, -1, 0);
      send_frame(8, 1'b0, 1'b0, 8'h33, 1'b0, 1'b1, 20, 99, -1, 0);
      chk("b2b.count", n_dv - s_dv, 3);
      if (n_dv - s_dv == 3) begin
         chk("b2b.d0", int'(pd_log[s_dv[8:0]]), 8'h11);
         chk("b2b.d1", int'(pd_log[9'(s_dv + 1)]), 8'h22);
         chk("b2b.d2", int'(pd_log[9'(s_dv + 2)]), 8'h33);
      end

      // Reset in the middle of the data bits.
      send_frame(16, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 0, 4, -1, 0);
      chk("midrst.busy_before", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("midrst.busy", int'(busy), 0);
      chk("midrst.cnt_enable", int'(cnt_enable), 0);
      chk("midrst.P_DATA", int'(P_DATA), 0);
      chk("midrst.pulses", int'({data_valid, par_err, stp_err}), 0);
      RX_IN = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      run_frame("after_rst", 16, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1, 0, 0, 8'hC3);

      // Illegal prescale: no pulses, controller must fall back to IDLE.
      s_dv = n_dv; s_pe = n_pe; s_se = n_se;
      send_frame(4, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 80, 99, -1, 0);
      chk("illegal.pulses", (n_dv - s_dv) + (n_pe - s_pe) + (n_se - s_se), 0);
      chk("illegal.busy", int'(busy), 0);
      chk("illegal.P_DATA", int'(P_DATA), 8'hC3);
      run_frame("after_illegal", 8, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1, 0, 0, 8'h5A);

      // Random frames against the reference outcome rules.
      for (int r = 0; r < 30; r++) begin
         int pre, ev, epe, ese;
         bit pen, ptyp, flip, stop;
         logic [7:0] data, epd;
         case ($urandom_range(0, 2))
            0:       pre = 8;
            1:       pre = 16;
            default: pre = 32;
         endcase
         pen  = 1'($urandom_range(0, 1));
         ptyp = 1'($urandom_range(0, 1));
         data = 8'($urandom);
         flip = pen && ($urandom_range(0, 3) == 0);
         stop = ($urandom_range(0, 4) != 0);
         epe  = flip ? 1 : 0;
         ese  = stop ? 0 : 1;
         ev   = (stop && !flip) ? 1 : 0;
         epd  = ev ? data : last_pd;
         run_frame($sformatf("rnd%0d", r), pre, pen, ptyp, data, flip, stop, ev, epe, ese, epd);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
